// File: rtl/pru_cmd_pkg.sv
// Shared definitions for the PRU command queue: word layout constants,
// default field widths, issue FSM states and the stored command type.
package pru_cmd_pkg;

    localparam int TAG_BIT   = 31;
    localparam int PAYLOAD_W = 31;

    localparam int DEF_DEPTH   = 4;
    localparam int DEF_COLOR_W = 2;
    localparam int DEF_ROW_W   = 10;
    localparam int DEF_COL_W   = 9;
    localparam int DEF_WIDTH_W = 10;
    localparam int DEF_HR_W    = 9;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } issue_state_e;

    // A queued command keeps both raw payloads; fields are decoded at issue time.
    typedef struct packed {
        logic [PAYLOAD_W-1:0] wordA;
        logic [PAYLOAD_W-1:0] wordB;
    } cmd_t;

endpackage

// File: rtl/pru_cmd_fifo.sv
// Synchronous DEPTH-entry command FIFO with flush; pointers wrap modulo DEPTH.
module pru_cmd_fifo
    import pru_cmd_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  cmd_t             data_i,
    output cmd_t             data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    cmd_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPush  = push_i && !full_o && !flush_i;
    assign doPop   = pop_i && !empty_o && !flush_i;
    assign data_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
            if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
            if (doPush && !doPop)      count_d = count_q + CNT_W'(1);
            else if (doPop && !doPush) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/pru_cmd_queue.sv
// Assembles two-word PRU commands, queues them, and issues one at a time
// to the PRU with a start pulse, holding the fields until pru_done.
module pru_cmd_queue
    import pru_cmd_pkg::*;
#(
    parameter  int DEPTH   = DEF_DEPTH,
    parameter  int COLOR_W = DEF_COLOR_W,
    parameter  int ROW_W   = DEF_ROW_W,
    parameter  int COL_W   = DEF_COL_W,
    parameter  int WIDTH_W = DEF_WIDTH_W,
    parameter  int HR_W    = DEF_HR_W,
    localparam int LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [31:0]        wr_data,
    output logic               wr_ready,
    input  logic               flush,
    input  logic               pru_busy,
    input  logic               pru_done,
    output logic               start,
    output logic [COLOR_W-1:0] color,
    output logic [ROW_W-1:0]   row,
    output logic [COL_W-1:0]   col,
    output logic [WIDTH_W-1:0] width,
    output logic [HR_W-1:0]    height_radius,
    output logic [1:0]         shape_select,
    output logic               subtract,
    output logic               color_load,
    output logic [LVL_W-1:0]   level,
    output logic               overflow,
    output logic               seq_err
);

    localparam int ROW_LSB = COLOR_W;
    localparam int COL_LSB = ROW_LSB + ROW_W;
    localparam int WID_LSB = COL_LSB + COL_W;
    localparam int A_USED  = WID_LSB + WIDTH_W;
    localparam int SHP_LSB = HR_W;
    localparam int SUB_BIT = HR_W + 2;
    localparam int CLD_BIT = HR_W + 3;
    localparam int B_USED  = HR_W + 4;

    logic                 accept;
    logic                 isWordB;
    logic                 push;
    logic                 loadOut;
    logic                 fifoFull;
    logic                 fifoEmpty;
    cmd_t                 pushCmd;
    cmd_t                 fifoHead;

    logic [PAYLOAD_W-1:0] pendingWord_q, pendingWord_d;
    logic                 pending_q, pending_d;
    logic                 overflow_q, overflow_d;
    logic                 seqErr_q, seqErr_d;
    logic                 start_q, start_d;
    issue_state_e         state_q, state_d;

    logic [COLOR_W-1:0]   color_q;
    logic [ROW_W-1:0]     row_q;
    logic [COL_W-1:0]     col_q;
    logic [WIDTH_W-1:0]   width_q;
    logic [HR_W-1:0]      hr_q;
    logic [1:0]           shape_q;
    logic                 subtract_q;
    logic                 colorLoad_q;

    assign wr_ready = !fifoFull;
    assign accept   = wr_en && wr_ready && !flush;
    assign isWordB  = wr_data[TAG_BIT];
    assign push     = accept && isWordB && pending_q;
    assign pushCmd  = '{wordA: pendingWord_q, wordB: wr_data[PAYLOAD_W-1:0]};

    pru_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (loadOut),
        .flush_i (flush),
        .data_i  (pushCmd),
        .data_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (level)
    );

    // Word pairing: out-of-order words flag seq_err; flush discards everything.
    always_comb begin
        pendingWord_d = pendingWord_q;
        pending_d     = pending_q;
        overflow_d    = overflow_q;
        seqErr_d      = 1'b0;
        if (flush) begin
            pending_d  = 1'b0;
            overflow_d = 1'b0;
        end else begin
            if (wr_en && !wr_ready) overflow_d = 1'b1;
            if (accept) begin
                if (isWordB) begin
                    seqErr_d  = !pending_q;
                    pending_d = 1'b0;
                end else begin
                    seqErr_d      = pending_q;
                    pending_d     = 1'b1;
                    pendingWord_d = wr_data[PAYLOAD_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendingWord_q <= '0;
            pending_q     <= 1'b0;
            overflow_q    <= 1'b0;
            seqErr_q      <= 1'b0;
        end else begin
            pendingWord_q <= pendingWord_d;
            pending_q     <= pending_d;
            overflow_q    <= overflow_d;
            seqErr_q      <= seqErr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // An ISSUE entered just as a flush emptied the FIFO has nothing to send.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (level != '0 && !pru_busy) state_d = ISSUE;
            ISSUE:     state_d = fifoEmpty ? IDLE : WAIT_DONE;
            WAIT_DONE: if (pru_done) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        loadOut = (state_q == ISSUE) && !fifoEmpty;
        start_d = loadOut;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q     <= 1'b0;
            color_q     <= '0;
            row_q       <= '0;
            col_q       <= '0;
            width_q     <= '0;
            hr_q        <= '0;
            shape_q     <= '0;
            subtract_q  <= 1'b0;
            colorLoad_q <= 1'b0;
        end else begin
            start_q <= start_d;
            if (loadOut) begin
                color_q     <= fifoHead.wordA[COLOR_W-1:0];
                row_q       <= fifoHead.wordA[ROW_LSB +: ROW_W];
                col_q       <= fifoHead.wordA[COL_LSB +: COL_W];
                width_q     <= fifoHead.wordA[WID_LSB +: WIDTH_W];
                hr_q        <= fifoHead.wordB[HR_W-1:0];
                shape_q     <= fifoHead.wordB[SHP_LSB +: 2];
                subtract_q  <= fifoHead.wordB[SUB_BIT];
                colorLoad_q <= fifoHead.wordB[CLD_BIT];
            end
        end
    end

    if (A_USED < PAYLOAD_W) begin : gUnusedA
        logic unusedA;
        assign unusedA = ^fifoHead.wordA[PAYLOAD_W-1:A_USED];
    end
    if (B_USED < PAYLOAD_W) begin : gUnusedB
        logic unusedB;
        assign unusedB = ^fifoHead.wordB[PAYLOAD_W-1:B_USED];
    end

    assign start         = start_q;
    assign color         = color_q;
    assign row           = row_q;
    assign col           = col_q;
    assign width         = width_q;
    assign height_radius = hr_q;
    assign shape_select  = shape_q;
    assign subtract      = subtract_q;
    assign color_load    = colorLoad_q;
    assign overflow      = overflow_q;
    assign seq_err       = seqErr_q;

endmodule

// File: tb/tb_pru_cmd_queue.sv
// Directed bench for pru_cmd_queue: a scoreboard of expected commands is
// filled as words are written and drained as start pulses appear.
module tb_pru_cmd_queue;

    localparam int DEPTH = 4;
    localparam int CW    = 2;
    localparam int RW    = 10;
    localparam int CLW   = 9;
    localparam int WW    = 10;
    localparam int HW    = 9;
    localparam int LVL_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [31:0]      wr_data = '0;
    logic             flush = 1'b0;
    logic             pru_busy = 1'b0;
    logic             pru_done = 1'b0;
    logic             wr_ready;
    logic             start;
    logic [CW-1:0]    color;
    logic [RW-1:0]    row;
    logic [CLW-1:0]   col;
    logic [WW-1:0]    width;
    logic [HW-1:0]    height_radius;
    logic [1:0]       shape_select;
    logic             subtract;
    logic             color_load;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic             seq_err;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } expCmd_t;

    expCmd_t     sbQ[$];
    int          checkCount = 0;
    int          passCount = 0;
    int          failCount = 0;
    int          startCount = 0;
    int          cycle = 0;
    int          lastDoneCycle = -100;
    int          doneDelay = 5;
    logic        holdActive = 1'b0;
    logic        holdEnding = 1'b0;
    logic [63:0] holdExp = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    pru_cmd_queue #(
        .DEPTH   (DEPTH),
        .COLOR_W (CW),
        .ROW_W   (RW),
        .COL_W   (CLW),
        .WIDTH_W (WW),
        .HR_W    (HW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .flush         (flush),
        .pru_busy      (pru_busy),
        .pru_done      (pru_done),
        .start         (start),
        .color         (color),
        .row           (row),
        .col           (col),
        .width         (width),
        .height_radius (height_radius),
        .shape_select  (shape_select),
        .subtract      (subtract),
        .color_load    (color_load),
        .level         (level),
        .overflow      (overflow),
        .seq_err       (seq_err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] makeA(input int c, input int r, input int cl, input int w);
        return {1'b0, WW'(w), CLW'(cl), RW'(r), CW'(c)};
    endfunction

    function automatic logic [31:0] makeB(input int hr, input int shp, input int sub, input int cld);
        return {1'b1, 18'b0, 1'(cld), 1'(sub), 2'(shp), HW'(hr)};
    endfunction

    // Reference decode of a command pair into the concatenated output fields.
    function automatic logic [63:0] expFields(input logic [31:0] a, input logic [31:0] b);
        return 64'({a[1:0], a[11:2], a[20:12], a[30:21], b[8:0], b[10:9], b[11], b[12]});
    endfunction

    function automatic logic [63:0] packFields();
        return 64'({color, row, col, width, height_radius, shape_select, subtract, color_load});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] word, input bit waitReady);
        int waitCycles;
        waitCycles = 0;
        if (waitReady) begin
            while (!wr_ready && waitCycles < 300) begin
                tick();
                waitCycles++;
            end
            if (!wr_ready) checkOutput("wrReadyTimeout", 64'(wr_ready), 64'd1);
        end
        wr_en   = 1'b1;
        wr_data = word;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic sendCmd(input logic [31:0] a, input logic [31:0] b);
        applyStimulus(a, 1'b1);
        applyStimulus(b, 1'b1);
        sbQ.push_back('{a: a, b: b});
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((sbQ.size() != 0 || holdActive) && c < budget) begin
            tick();
            c++;
        end
        checkOutput("drainPending", 64'(sbQ.size()), 64'd0);
        tick();
    endtask

    // PRU model: answers each start with a one-cycle pru_done after doneDelay edges.
    always begin
        @(negedge clk);
        if (rst_n && start) begin
            repeat (doneDelay) @(posedge clk);
            #1 pru_done = 1'b1;
            @(posedge clk);
            #1 pru_done = 1'b0;
        end
    end

    // Issue monitor: compares each start against the scoreboard head and
    // verifies the fields stay put through the cycle after pru_done.
    always @(negedge clk) begin
        if (!rst_n) begin
            holdActive = 1'b0;
            holdEnding = 1'b0;
        end else begin
            if (start) begin
                expCmd_t e;
                startCount++;
                checkOutput("startWithExpected", 64'(sbQ.size() != 0), 64'd1);
                if (sbQ.size() != 0) begin
                    e = sbQ.pop_front();
                    holdExp = expFields(e.a, e.b);
                    checkOutput("issueFields", packFields(), holdExp);
                    holdActive = 1'b1;
                    holdEnding = 1'b0;
                end
                checkOutput("startGap", 64'((cycle - lastDoneCycle) >= 2), 64'd1);
            end else if (holdActive) begin
                checkOutput("holdFields", packFields(), holdExp);
                if (holdEnding) holdActive = 1'b0;
            end
            if (pru_done) begin
                lastDoneCycle = cycle;
                if (holdActive) holdEnding = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, observed running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sc;
        int c;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetStart", 64'(start), 64'd0);
        checkOutput("resetLevel", 64'(level), 64'd0);
        checkOutput("resetWrReady", 64'(wr_ready), 64'd1);
        checkOutput("resetOverflow", 64'(overflow), 64'd0);
        checkOutput("resetSeqErr", 64'(seq_err), 64'd0);
        checkOutput("resetFields", packFields(), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single command with minimum latency
        $display("[TB] single command");
        pru_busy  = 1'b0;
        doneDelay = 5;
        applyStimulus(32'h01E0A02B, 1'b1);
        applyStimulus(32'h8000000F, 1'b1);
        sbQ.push_back('{a: 32'h01E0A02B, b: 32'h8000000F});
        @(negedge clk);
        checkOutput("latLevel", 64'(level), 64'd1);
        checkOutput("latStart1", 64'(start), 64'd0);
        @(negedge clk);
        checkOutput("latStart2", 64'(start), 64'd0);
        @(negedge clk);
        checkOutput("latStart3", 64'(start), 64'd1);
        checkOutput("singleRow", 64'(row), 64'd10);
        checkOutput("singleCol", 64'(col), 64'd10);
        checkOutput("singleWidth", 64'(width), 64'd15);
        checkOutput("singleColor", 64'(color), 64'd3);
        checkOutput("singleHr", 64'(height_radius), 64'd15);
        checkOutput("singleShape", 64'(shape_select), 64'd0);
        drain(100);
        checkOutput("singleLevelAfter", 64'(level), 64'd0);

        // Word-order errors
        $display("[TB] order errors");
        sc = startCount;
        applyStimulus(32'h8000000F, 1'b1);
        @(negedge clk);
        checkOutput("orphanBSeqErr", 64'(seq_err), 64'd1);
        checkOutput("orphanBLevel", 64'(level), 64'd0);
        @(negedge clk);
        checkOutput("orphanBSeqErrClear", 64'(seq_err), 64'd0);
        repeat (5) tick();
        checkOutput("orphanBNoStart", 64'(startCount - sc), 64'd0);
        applyStimulus(makeA(1, 5, 6, 7), 1'b1);
        applyStimulus(makeA(2, 20, 30, 40), 1'b1);
        @(negedge clk);
        checkOutput("doubleASeqErr", 64'(seq_err), 64'd1);
        applyStimulus(makeB(100, 2, 1, 0), 1'b1);
        sbQ.push_back('{a: makeA(2, 20, 30, 40), b: makeB(100, 2, 1, 0)});
        @(negedge clk);
        checkOutput("replacedAPairSeqErr", 64'(seq_err), 64'd0);
        drain(100);

        // Overflow with the PRU busy, then flush
        $display("[TB] overflow and flush");
        pru_busy = 1'b1;
        sc = startCount;
        for (int i = 0; i < DEPTH; i++) begin
            sendCmd(makeA(i, 100 + i, i, i), makeB(i, 1, 0, 1));
        end
        checkOutput("fullLevel", 64'(level), 64'(DEPTH));
        checkOutput("fullWrReady", 64'(wr_ready), 64'd0);
        checkOutput("fullNoOverflowYet", 64'(overflow), 64'd0);
        applyStimulus(makeA(3, 99, 9, 9), 1'b0);
        applyStimulus(makeB(9, 0, 0, 0), 1'b0);
        checkOutput("overflowSet", 64'(overflow), 64'd1);
        checkOutput("overflowLevel", 64'(level), 64'(DEPTH));
        checkOutput("busyNoStart", 64'(startCount - sc), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sbQ.delete();
        checkOutput("flushLevel", 64'(level), 64'd0);
        checkOutput("flushOverflow", 64'(overflow), 64'd0);
        checkOutput("flushWrReady", 64'(wr_ready), 64'd1);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = makeA(1, 1, 1, 1);
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        applyStimulus(makeB(1, 1, 1, 1), 1'b1);
        @(negedge clk);
        checkOutput("flushDroppedWordA", 64'(seq_err), 64'd1);
        checkOutput("flushDroppedLevel", 64'(level), 64'd0);
        pru_busy = 1'b0;
        repeat (10) tick();
        checkOutput("flushNoStart", 64'(startCount - sc), 64'd0);

        // Back-to-back commands
        $display("[TB] back-to-back");
        doneDelay = 5;
        sc = startCount;
        for (int i = 0; i < 3; i++) begin
            sendCmd(makeA(i, 201 + i, 50 + i, 60 + i), makeB(70 + i, i, 1, i % 2));
        end
        drain(200);
        checkOutput("b2bStarts", 64'(startCount - sc), 64'd3);

        // Ten commands through the FIFO, exercising pointer wrap
        $display("[TB] wrap");
        sc = startCount;
        for (int i = 1; i <= 10; i++) begin
            sendCmd(makeA(i % 4, i, 10 + i, 20 + i), makeB(i, i % 3, i % 2, 0));
        end
        drain(400);
        checkOutput("wrapStarts", 64'(startCount - sc), 64'd10);

        // Reset while waiting for the PRU with two commands queued
        $display("[TB] reset mid-operation");
        doneDelay = 60;
        sc = startCount;
        sendCmd(makeA(1, 300, 1, 1), makeB(1, 0, 0, 0));
        c = 0;
        while (startCount == sc && c < 20) begin
            tick();
            c++;
        end
        checkOutput("midFirstStart", 64'(startCount - sc), 64'd1);
        sendCmd(makeA(2, 301, 2, 2), makeB(2, 0, 0, 0));
        sendCmd(makeA(3, 302, 3, 3), makeB(3, 0, 0, 0));
        checkOutput("midQueued", 64'(level), 64'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("midResetStart", 64'(start), 64'd0);
        checkOutput("midResetLevel", 64'(level), 64'd0);
        sbQ.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        sc = startCount;
        repeat (20) tick();
        checkOutput("postResetNoStart", 64'(startCount - sc), 64'd0);
        checkOutput("postResetLevel", 64'(level), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/pru_cmd_queue.md
PRU_CMD_QUEUE -- requirements
Module: pru_cmd_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of command slots; it must be a power of two and at least 2.
REQ-002 The block SHALL have parameter COLOR_W, default 2, giving the color field width.
REQ-003 The block SHALL have parameter ROW_W, default 10, giving the row field width.
REQ-004 The block SHALL have parameter COL_W, default 9, giving the column field width.
REQ-005 The block SHALL have parameter WIDTH_W, default 10, giving the width field width.
REQ-006 The block SHALL have parameter HR_W, default 9, giving the height/radius field width; COLOR_W+ROW_W+COL_W+WIDTH_W and HR_W+4 SHALL each be at most 31.
REQ-007 The block SHALL have these ports:
  - clk  in  1  single clock.
  - rst_n  in  1  reset, asynchronous, active-low.
  - wr_en  in  1  command word strobe.
  - wr_data  in  32  command word.
  - wr_ready  out  1  queue not full.
  - flush  in  1  discard queued and partial commands.
  - pru_busy  in  1  PRU busy.
  - pru_done  in  1  PRU completion pulse.
  - start  out  1  one-cycle issue pulse.
  - color  out  COLOR_W  color field.
  - row  out  ROW_W  row field.
  - col  out  COL_W  column field.
  - width  out  WIDTH_W  width field.
  - height_radius  out  HR_W  height or radius field.
  - shape_select  out  2  shape field.
  - subtract  out  1  subtract flag.
  - color_load  out  1  color load flag.
  - level  out  $clog2(DEPTH)+1  number of queued commands.
  - overflow  out  1  sticky write-while-full error.
  - seq_err  out  1  one-cycle word-order error pulse.

Function
REQ-008 Bit 31 of every command word SHALL be its tag: 0 = word A, 1 = word B.
REQ-009 Word A fields SHALL be packed contiguously from bit 0 upward in this order: color, row, col, width.
REQ-010 Word B fields SHALL be packed contiguously from bit 0 upward in this order: height_radius, shape_select, subtract, color_load.
REQ-011 A word A accepted (wr_en && wr_ready) SHALL be held in a pending register and set the pending flag.
REQ-012 A word B accepted while pending is set SHALL push one {A,B} command into the FIFO at that edge and clear pending.
REQ-013 A word B accepted while pending is clear SHALL be dropped and SHALL pulse seq_err for the following cycle.
REQ-014 A word A accepted while pending is set SHALL replace the pending word and SHALL pulse seq_err for the following cycle.
REQ-015 wr_ready SHALL equal (level != DEPTH).
REQ-016 A wr_en while wr_ready is low SHALL be dropped and SHALL set overflow; overflow SHALL stay set until flush or reset.
REQ-017 The issue FSM SHALL have three states: IDLE, ISSUE, WAIT_DONE.
REQ-018 IDLE SHALL go to ISSUE when level>0 and pru_busy is low.
REQ-019 ISSUE SHALL pop the FIFO head into the output registers, assert start for exactly that cycle, and go to WAIT_DONE.
REQ-020 WAIT_DONE SHALL return to IDLE on pru_done; start SHALL stay low in WAIT_DONE.
REQ-021 All field outputs SHALL be registered and SHALL hold constant from start until the cycle after pru_done.
REQ-022 The minimum latency SHALL be that a word B accepted at edge N into an empty queue with the PRU idle produces start high in the cycle following edge N+2.
REQ-023 Consecutive start pulses SHALL be separated by at least one IDLE cycle after pru_done.
REQ-024 A push and a pop in the same cycle SHALL leave level unchanged.
REQ-025 When the FIFO is full, a word B SHALL be refused because wr_ready is low; the pending word A SHALL be retained.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH.
REQ-027 flush SHALL clear the FIFO, level, pending and overflow at that edge.
REQ-028 flush SHALL win over a simultaneous wr_en, and that word SHALL be dropped.
REQ-029 flush SHALL NOT abort WAIT_DONE.
REQ-030 flush during ISSUE SHALL still complete that issue.

Reset
REQ-031 rst_n low SHALL asynchronously clear the following: FSM to IDLE, FIFO pointers, level, pending, overflow, seq_err, start, and all field outputs.
REQ-032 A reset asserted mid-command SHALL abandon the command with no pulse to the PRU; the block SHALL resume in IDLE on the first edge after rst_n rises.

Structure
REQ-033 A shared package SHALL hold the following: the tag bit position, the default field widths, the FSM state enum, and the packed command struct type.
REQ-034 Storage SHALL be one sub-module, pru_cmd_fifo: a synchronous DEPTH-entry FIFO with push, pop, flush, full, empty and count.
REQ-035 Word assembly and the issue FSM SHALL reside in pru_cmd_queue.

Verification
REQ-036 Single command: word A 0x01E0A02B, then word B 0x8000000F, with the PRU idle -> one start pulse; row=10, col=10, width=15, color=3, height_radius=15, shape_select=0; outputs held until pru_done.
REQ-037 Order error: word B 0x8000000F with nothing pending -> seq_err one cycle, level stays 0, no start.
REQ-038 Overflow: with pru_busy high, write DEPTH+1 complete commands -> wr_ready low after DEPTH commands, overflow=1, level=DEPTH; then flush -> level=0, overflow=0.
REQ-039 Back-to-back: 3 queued commands, pru_done 5 cycles after each start -> 3 starts in FIFO order, each at least 1 cycle after the previous pru_done.
REQ-040 Wrap: with DEPTH=4, push/pop 10 commands with distinct rows 1..10 -> issued rows are 1..10 in order.
REQ-041 Reset mid-operation: rst_n low during WAIT_DONE with 2 commands queued -> start=0 and level=0 immediately; after release, no start without new words.
